// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, port indices and default lock budget.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int LOCK_MAX_DEF = 4;
  localparam int ADDR_W_DEF   = 10;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the shared synchronous memory bus.
// slave faces the arbiter, master faces requesters and memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic              lock0;
  logic              lock1;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  lock0, lock1,
    input  addr0, addr1,
    input  wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1,
    output done0, done1,
    output rdata0, rdata1,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1,
    output lock0, lock1,
    output addr0, addr1,
    output wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1,
    input  done0, done1,
    input  rdata0, rdata1,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter_pick.sv
// Two-way picker: lone requester wins, else an eligible
// locked owner, else the port named by prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       owner,
  input  logic       own_ok,
  output logic [1:0] gnt
);

  logic win;

  assign win = own_ok ? owner : prio;

  // one-hot grant from the request pattern
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt[win] = 1'b1;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous data memory.
// One access per IDLE->CMD->DATA pass, with lock-limited ownership.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input logic      clock,
  input logic      resetn,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic             prio;
  logic             owner;
  logic             cur;
  logic             rd;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic             own_ok;
  logic             grant;
  logic             win;
  logic             serve_rd;
  logic [31:0]      rd0_q;
  logic [31:0]      rd1_q;
  logic             unused_addr;

  assign unused_addr = ^{bus.addr0[31:ADDR_W+2],
                         bus.addr0[1:0],
                         bus.addr1[31:ADDR_W+2],
                         bus.addr1[1:0]};

  assign req = {bus.req1, bus.req0}
             & {2{(state == IDLE) & resetn}};

  assign own_ok = (owner ? bus.lock1 : bus.lock0)
                & (lock_cnt < CNT_MAX);

  rr_pick2 u_pick (
    .req    (req),
    .prio   (prio),
    .owner  (owner),
    .own_ok (own_ok),
    .gnt    (pick)
  );

  assign grant    = |pick;
  assign win      = pick[1];
  assign bus.gnt0 = pick[0];
  assign bus.gnt1 = pick[1];

  // next-state: one pass through CMD and DATA per grant
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = grant ? CMD : IDLE;
      CMD:     state_n = DATA;
      DATA:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // arbitration history: owner, prio, lock run length
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prio     <= PORT_CPU;
      owner    <= PORT_CPU;
      cur      <= PORT_CPU;
      rd       <= 1'b0;
      lock_cnt <= '0;
    end else if (grant) begin
      owner <= win;
      prio  <= other_port(win);
      cur   <= win;
      rd    <= ~(win ? bus.we1 : bus.we0);
      if (win != owner)
        lock_cnt <= CNT_ONE;
      else if (lock_cnt != CNT_MAX)
        lock_cnt <= lock_cnt + CNT_ONE;
    end
  end

  // memory command latched from the winner at grant
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= grant;
      bus.mem_we <= 1'b0;
      if (grant) begin
        bus.mem_we    <= win ? bus.we1 : bus.we0;
        bus.mem_addr  <= win ? bus.addr1[ADDR_W+1:2]
                             : bus.addr0[ADDR_W+1:2];
        bus.mem_wdata <= win ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  assign serve_rd = (state == DATA) & rd;

  // keep each port's last read word once DATA ends
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else if (serve_rd) begin
      if (cur) rd1_q <= bus.mem_rdata;
      else     rd0_q <= bus.mem_rdata;
    end
  end

  assign bus.done0  = (state == DATA) & ~cur;
  assign bus.done1  = (state == DATA) & cur;
  assign bus.rdata0 = (serve_rd & ~cur) ? bus.mem_rdata
                                         : rd0_q;
  assign bus.rdata1 = (serve_rd & cur) ? bus.mem_rdata
                                        : rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural
// synchronous memory model; word 4 preloads 0xDEADBEEF.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(10)) bus ();

  dmem_arbiter #(.ADDR_W(10), .LOCK_MAX(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:1023];
  logic [1023:0] vld = '0;

  // synchronous memory: write or read when enabled
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        vld[bus.mem_addr] <= 1'b1;
      end
      if (vld[bus.mem_addr])
        bus.mem_rdata <= mem[bus.mem_addr];
      else if (bus.mem_addr == 10'd4)
        bus.mem_rdata <= 32'hDEADBEEF;
      else
        bus.mem_rdata <= 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0;
    bus.we0 = 0; bus.we1 = 0;
    bus.lock0 = 0; bus.lock1 = 0;
    bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1;
  endtask

  int gp [0:7];
  int gc [0:7];
  int both;

  task automatic collect(input int n);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    both = 0;
    while (k < n && cyc < 40) begin
      mid();
      if (bus.gnt0 && bus.gnt1) both++;
      if (bus.gnt0 || bus.gnt1) begin
        gp[k] = bus.gnt1 ? 1 : 0;
        gc[k] = cyc;
        k++;
      end
      cyc++;
      step();
    end
    chk("grant_count", k, n);
    chk("onehot", both, 0);
  endtask

  int exp4 [0:6] = '{0, 1, 1, 1, 1, 0, 1};
  int n_g0, n_g1, n_d0, n_d1, k_g0;

  initial begin
    idle_inputs();
    bus.mem_rdata = 0;

    // reset state, with a request pending
    resetn = 0;
    bus.req1 = 1;
    mid();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_done", {bus.done0, bus.done1}, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);

    // single CPU read of word 4
    do_reset();
    bus.req0 = 1; bus.addr0 = 32'h10;
    mid();
    chk("rd_gnt0", bus.gnt0, 1);
    chk("rd_gnt1", bus.gnt1, 0);
    step();
    bus.req0 = 0;
    mid();
    chk("rd_mem_en", bus.mem_en, 1);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_mem_addr", bus.mem_addr, 4);
    chk("rd_gnt_cmd", bus.gnt0, 0);
    step();
    mid();
    chk("rd_done0", bus.done0, 1);
    chk("rd_rdata0", bus.rdata0, 32'hDEADBEEF);
    chk("rd_mem_en_off", bus.mem_en, 0);
    step();
    mid();
    chk("rd_done0_off", bus.done0, 0);
    chk("rd_rdata0_hold", bus.rdata0, 32'hDEADBEEF);

    // both requesting, no lock: alternate, 3 cycles apart
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    collect(4);
    chk("alt_first", gc[0], 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt_port%0d", i), gp[i], i % 2);
    for (int i = 0; i < 3; i++)
      chk($sformatf("alt_gap%0d", i), gc[i+1] - gc[i], 3);

    // lock on port 1: four grants then yield
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.lock1 = 1;
    collect(7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("lock_port%0d", i), gp[i], exp4[i]);

    // port 1 write then port 0 read-back
    do_reset();
    bus.req1 = 1; bus.we1 = 1;
    bus.addr1 = 32'h20; bus.wdata1 = 32'h12345678;
    mid();
    chk("wr_gnt1", bus.gnt1, 1);
    step();
    bus.req1 = 0; bus.we1 = 0; bus.wdata1 = 0;
    mid();
    chk("wr_mem_en", bus.mem_en, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 8);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
    step();
    mid();
    chk("wr_done1", bus.done1, 1);
    chk("wr_rdata1", bus.rdata1, 0);
    step();
    bus.req0 = 1; bus.addr0 = 32'h20;
    mid();
    chk("rb_gnt0", bus.gnt0, 1);
    step();
    bus.req0 = 0;
    step();
    mid();
    chk("rb_done0", bus.done0, 1);
    chk("rb_rdata0", bus.rdata0, 32'h12345678);

    // reset during CMD aborts the port 0 read
    do_reset();
    bus.req0 = 1; bus.addr0 = 32'h10;
    mid();
    chk("ab_gnt0", bus.gnt0, 1);
    step();
    bus.req0 = 0;
    bus.req1 = 1; bus.addr1 = 32'h10;
    mid();
    chk("ab_cmd", bus.mem_en, 1);
    resetn = 0;
    #1;
    chk("ab_rst_gnt1", bus.gnt1, 0);
    chk("ab_rst_done0", bus.done0, 0);
    chk("ab_rst_mem_en", bus.mem_en, 0);
    chk("ab_rst_mem_addr", bus.mem_addr, 0);
    chk("ab_rst_rdata0", bus.rdata0, 0);
    step();
    resetn = 1;
    mid();
    chk("ab_gnt1", bus.gnt1, 1);
    chk("ab_no_done0_a", bus.done0, 0);
    step();
    bus.req1 = 0;
    mid();
    chk("ab_no_done0_b", bus.done0, 0);
    step();
    mid();
    chk("ab_done1", bus.done1, 1);
    chk("ab_no_done0_c", bus.done0, 0);
    chk("ab_rdata1", bus.rdata1, 32'hDEADBEEF);

    // req0 pulsed while busy, re-raised later
    do_reset();
    n_g0 = 0; n_g1 = 0; n_d0 = 0; n_d1 = 0;
    k_g0 = -1;
    bus.addr0 = 32'h10; bus.addr1 = 32'h10;
    for (int k = 0; k < 10; k++) begin
      bus.req1 = (k == 0);
      bus.req0 = (k == 1) || (k == 4);
      mid();
      if (bus.gnt0) begin n_g0++; k_g0 = k; end
      if (bus.gnt1) n_g1++;
      if (bus.done0) n_d0++;
      if (bus.done1) n_d1++;
      step();
    end
    chk("drop_gnt0_n", n_g0, 1);
    chk("drop_gnt0_k", k_g0, 4);
    chk("drop_gnt1_n", n_g1, 1);
    chk("drop_done0_n", n_d0, 1);
    chk("drop_done1_n", n_d1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
